pulse_stretch: RTL and testbench
================================

// Module: pulse_stretch
// PURPOSE
// - Downstream consumer of the single-cycle PULSE strobe from the pulse transition FSM.
// - Turns each accepted strobe into an OUT_PULSE of programmable width, followed by a
//   programmable hold-off window. Strobes that cannot be served are counted as missed.
// - Sits between the pulse-generation FSM and the external pulse driver / status logic.
// PARAMETERS
// - WIDTH_W    default 8   width of the WIDTH config input (pulse length in cycles)
// - HOLDOFF_W  default 8   width of the HOLDOFF config input (dead time in cycles)
// - MISS_W     default 8   width of the saturating MISSED_CNT counter
// PORTS
// - CLK         in   1          clock; all logic is on posedge CLK
// - RSTN        in   1          reset; asynchronous, active-low
// - EN          in   1          1 = accept new triggers; 0 = ignore triggers
// - TRIG        in   1          trigger strobe; connects to the upstream PULSE output
// - WIDTH       in   WIDTH_W    OUT_PULSE length in cycles; 0 is treated as 1
// - HOLDOFF     in   HOLDOFF_W  dead cycles after OUT_PULSE falls; 0 = no hold-off
// - OUT_PULSE   out  1          stretched pulse, registered
// - BUSY        out  1          high in SACTIVE or SHOLD
// - DONE        out  1          one-cycle strobe on the first SIDLE cycle after a pulse
// - MISSED_CNT  out  MISS_W     saturating count of dropped triggers
// BEHAVIOUR
// - Reset state:
//   - state=SIDLE; OUT_PULSE=0, BUSY=0, DONE=0, MISSED_CNT=0; counters cleared.
//   - Reset asserted mid-pulse aborts immediately, with no DONE.
// - States are SIDLE, SACTIVE and SHOLD. OUT_PULSE, BUSY and DONE are registered,
//   decoded from the next state.
// - SIDLE: when TRIG=1 and EN=1 in cycle t:
//   - Latch Wl=max(WIDTH,1) and Hl=HOLDOFF.
//   - Go to SACTIVE; OUT_PULSE=1 from cycle t+1 (latency 1).
// - SACTIVE: OUT_PULSE stays high for exactly Wl cycles (t+1..t+Wl). Then:
//   - if Hl>0: go to SHOLD for Hl cycles (t+Wl+1..t+Wl+Hl), with OUT_PULSE=0 and BUSY=1;
//   - if Hl=0: go to SIDLE at t+Wl+1.
// - Return to SIDLE:
//   - DONE=1 for exactly one cycle, the first SIDLE cycle.
//   - A TRIG in that same cycle is accepted, which gives back-to-back service.
// - Config inputs: WIDTH and HOLDOFF changes while BUSY do not affect the pulse in flight.
// - TRIG while BUSY (EN=1): dropped; MISSED_CNT+=1, saturating at 2^MISS_W-1
//   (except as noted under CONFIGURATION).
// - EN=0:
//   - TRIG is ignored and not counted as missed.
//   - A pulse already in flight still completes normally, including DONE.
// - Simultaneous TRIG and the final SHOLD cycle: TRIG is missed. Only SIDLE accepts triggers.
// - Down-counters:
//   - Width counter loads Wl-1; hold-off counter loads Hl-1.
//   - Each decrements to 0; no wrap-around is allowed.
// CONFIGURATION
// - Macro PULSE_STRETCH_RETRIGGER_EN.
// - Defined:
//   - TRIG&EN in SACTIVE reloads the width counter from the current WIDTH (0 treated as 1).
//   - OUT_PULSE then stays high Wl more cycles from the next cycle; MISSED_CNT is unchanged.
//   - TRIG in SHOLD is still missed.
// - Undefined: TRIG in SACTIVE is missed, per BEHAVIOUR.
// STRUCTURE
// - Package pulse_pkg holds:
//   - state encodings SIDLE=2'd0, SACTIVE=2'd1, SHOLD=2'd2;
//   - default widths WIDTH_W, HOLDOFF_W, MISS_W.
// - Sub-module pulse_down_counter is a loadable down-counter with a zero flag.
//   It is instantiated twice: once for width, once for hold-off.
// - Keep a comb next-state block separate from a sequential block.
// - A non-synthesis statename decode is provided.
// TESTING
// - W=3,H=2,EN=1, TRIG at cyc 10 -> OUT_PULSE 11..13, BUSY 11..15, DONE at 16, MISSED=0
// - W=0,H=0, TRIG at 10 -> OUT_PULSE only cyc 11; DONE at 12; TRIG at 12 -> OUT_PULSE at 13
// - W=4,H=3, TRIGs at 10,12,16 -> first served; 12,16 missed; MISSED_CNT=2
//   (retrigger build: 12 extends OUT_PULSE to 13..16; 16 missed -> MISSED_CNT=1)
// - EN=0, TRIG at 10 -> no OUT_PULSE, MISSED=0; EN drop mid-pulse -> pulse and DONE complete
// - Hold TRIG=1 for 300 cycles with W=1,H=255 -> MISSED_CNT saturates at 255
// - RSTN low at cyc 12 of a W=5 pulse -> all outputs 0 asynchronously; no DONE after release

Source files
------------

// File: rtl/pulse_pkg.sv
// -----------------------------------------------------------------------------
// pulse_pkg
// Shared types and defaults for the pulse stretcher slice.
//   state_e      : FSM encoding (SIDLE / SACTIVE / SHOLD)
//   DEF_*_W      : default widths for WIDTH, HOLDOFF and MISSED_CNT
//   state_name() : simulation-only state decode for debug printing
// -----------------------------------------------------------------------------
package pulse_pkg;

  localparam int DEF_WIDTH_W   = 8;
  localparam int DEF_HOLDOFF_W = 8;
  localparam int DEF_MISS_W    = 8;

  typedef enum logic [1:0] {
    SIDLE   = 2'd0,
    SACTIVE = 2'd1,
    SHOLD   = 2'd2
  } state_e;

`ifndef SYNTHESIS
  function automatic string state_name(state_e s);
    case (s)
      SIDLE:   return "SIDLE";
      SACTIVE: return "SACTIVE";
      SHOLD:   return "SHOLD";
      default: return "SILLEGAL";
    endcase
  endfunction
`endif

endpackage

// File: rtl/pulse_stretch_if.sv
// -----------------------------------------------------------------------------
// pulse_stretch_if
// Trigger/config/status bundle between the pulse FSM side and the stretcher.
//   EN, TRIG          : trigger enable and strobe
//   WIDTH, HOLDOFF    : pulse length / dead time config
//   OUT_PULSE, BUSY,
//   DONE, MISSED_CNT  : stretcher outputs
// master = trigger/config source, slave = pulse_stretch.
// -----------------------------------------------------------------------------
interface pulse_stretch_if
  import pulse_pkg::*;
#(
  parameter int WIDTH_W   = DEF_WIDTH_W,
  parameter int HOLDOFF_W = DEF_HOLDOFF_W,
  parameter int MISS_W    = DEF_MISS_W
);

  logic                 EN;
  logic                 TRIG;
  logic [WIDTH_W-1:0]   WIDTH;
  logic [HOLDOFF_W-1:0] HOLDOFF;
  logic                 OUT_PULSE;
  logic                 BUSY;
  logic                 DONE;
  logic [MISS_W-1:0]    MISSED_CNT;

  modport master (
    output EN, TRIG, WIDTH, HOLDOFF,
    input  OUT_PULSE, BUSY, DONE, MISSED_CNT
  );

  modport slave (
    input  EN, TRIG, WIDTH, HOLDOFF,
    output OUT_PULSE, BUSY, DONE, MISSED_CNT
  );

endinterface

// File: rtl/pulse_down_counter.sv
// -----------------------------------------------------------------------------
// pulse_down_counter
// Loadable down-counter with zero flag. Stops at zero (never wraps).
//   CLK, RSTN : clock, async active-low reset (clears count)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one if not already zero
//   zero      : count == 0
// -----------------------------------------------------------------------------
module pulse_down_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                  cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
// Turns each accepted TRIG strobe into an OUT_PULSE of WIDTH cycles (0 -> 1),
// followed by HOLDOFF dead cycles. Triggers that arrive while busy are counted
// in a saturating MISSED_CNT. Only SIDLE accepts new triggers.
//
// Ports:
//   CLK, RSTN : clock, async active-low reset
//   bus       : pulse_stretch_if.slave
//                 in : EN, TRIG, WIDTH, HOLDOFF
//                 out: OUT_PULSE, BUSY, DONE, MISSED_CNT (all registered)
//
// Build option:
//   PULSE_STRETCH_RETRIGGER_EN : TRIG&EN during SACTIVE reloads the width
//   counter from the current WIDTH instead of being counted as missed.
//   A trigger on the last SACTIVE cycle (width counter already at zero) is
//   still missed, as is any trigger during SHOLD.
// -----------------------------------------------------------------------------
module pulse_stretch
  import pulse_pkg::*;
#(
  parameter int WIDTH_W   = DEF_WIDTH_W,
  parameter int HOLDOFF_W = DEF_HOLDOFF_W,
  parameter int MISS_W    = DEF_MISS_W
) (
  input logic            CLK,
  input logic            RSTN,
  pulse_stretch_if.slave bus
);

  state_e               state, state_nxt;
  logic [HOLDOFF_W-1:0] hold_l;      // HOLDOFF captured at trigger time
  logic                 trig_acc;    // trigger accepted from SIDLE
  logic                 miss;        // trigger dropped this cycle
  logic                 trig_en;

  logic                 w_load, w_dec, w_zero;
  logic                 h_load, h_dec, h_zero;
  logic [WIDTH_W-1:0]   w_load_val;
  logic [HOLDOFF_W-1:0] h_load_val;

  logic                 out_q, busy_q, done_q;
  logic [MISS_W-1:0]    missed_q;

  assign trig_en = bus.TRIG & bus.EN;

  // Wl-1 with WIDTH==0 treated as 1; taken from the live input so the
  // retrigger path reloads from the current WIDTH.
  assign w_load_val = (bus.WIDTH == '0) ? '0 : bus.WIDTH - WIDTH_W'(1);
  // Only used on SACTIVE->SHOLD, where hold_l is known nonzero.
  assign h_load_val = hold_l - HOLDOFF_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state / counter control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    trig_acc  = 1'b0;
    miss      = 1'b0;
    w_load    = 1'b0;
    w_dec     = 1'b0;
    h_load    = 1'b0;
    h_dec     = 1'b0;
    case (state)
      SIDLE: begin
        if (trig_en) begin
          trig_acc  = 1'b1;
          w_load    = 1'b1;
          state_nxt = SACTIVE;
        end
      end
      SACTIVE: begin
        if (w_zero) begin
          if (hold_l != '0) begin
            h_load    = 1'b1;
            state_nxt = SHOLD;
          end else begin
            state_nxt = SIDLE;
          end
        end else begin
          w_dec = 1'b1;
        end
        if (trig_en) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
          if (!w_zero) begin
            w_load = 1'b1;
            w_dec  = 1'b0;
          end else begin
            miss = 1'b1;
          end
`else
          miss = 1'b1;
`endif
        end
      end
      SHOLD: begin
        if (h_zero) state_nxt = SIDLE;
        else        h_dec     = 1'b1;
        if (trig_en) miss = 1'b1;
      end
      default: state_nxt = SIDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs (decoded from next state)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= SIDLE;
      hold_l   <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= '0;
    end else begin
      state  <= state_nxt;
      if (trig_acc) hold_l <= bus.HOLDOFF;
      out_q  <= (state_nxt == SACTIVE);
      busy_q <= (state_nxt != SIDLE);
      // first SIDLE cycle after a pulse; reset leaves state at SIDLE so no
      // DONE follows an aborted pulse
      done_q <= (state != SIDLE) && (state_nxt == SIDLE);
      if (miss && missed_q != '1) missed_q <= missed_q + MISS_W'(1);
    end
  end

  pulse_down_counter #(.W(WIDTH_W)) u_wcnt (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .load     (w_load),
    .load_val (w_load_val),
    .dec      (w_dec),
    .zero     (w_zero)
  );

  pulse_down_counter #(.W(HOLDOFF_W)) u_hcnt (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .load     (h_load),
    .load_val (h_load_val),
    .dec      (h_dec),
    .zero     (h_zero)
  );

  assign bus.OUT_PULSE  = out_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.MISSED_CNT = missed_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretch
// Scoreboard bench: expected per-cycle outputs are queued when stimulus is
// set up and compared on the falling edge of the matching cycle.
// Cycle numbers in the tests are relative to the cycle reset was released.
// -----------------------------------------------------------------------------
module tb_pulse_stretch;

  logic CLK;
  logic RSTN;

  pulse_stretch_if #(.WIDTH_W(8), .HOLDOFF_W(8), .MISS_W(8)) bus ();

  pulse_stretch #(.WIDTH_W(8), .HOLDOFF_W(8), .MISS_W(8)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int base   = 0;

  typedef struct {
    int         cyc;
    logic       o;
    logic       b;
    logic       d;
    logic [7:0] m;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // bits lo..hi set
  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic push_one(input string tag, input int c, input logic o, input logic b,
                          input logic d, input logic [7:0] m);
    exp_t e;
    e.cyc = base + c; e.o = o; e.b = b; e.d = d; e.m = m; e.tag = tag;
    q.push_back(e);
  endtask

  // One entry per cycle lo..hi; miss count at c = triggers dropped before c.
  task automatic push_win(input string tag, input int lo, input int hi,
                          input logic [31:0] om, input logic [31:0] bm,
                          input logic [31:0] dm, input logic [31:0] mm);
    for (int c = lo; c <= hi; c++) begin
      logic [7:0] cnt;
      cnt = 8'd0;
      for (int k = 0; k < c; k++) if (mm[k]) cnt++;
      push_one(tag, c, om[c], bm[c], dm[c], cnt);
    end
  endtask

  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e_mon = q.pop_front();
      if (e_mon.cyc < cyc) begin
        chk($sformatf("%s.late@%0d", e_mon.tag, e_mon.cyc - base), cyc, e_mon.cyc);
      end else begin
        chk($sformatf("%s.out@%0d",    e_mon.tag, cyc - base), bus.OUT_PULSE,  e_mon.o);
        chk($sformatf("%s.busy@%0d",   e_mon.tag, cyc - base), bus.BUSY,       e_mon.b);
        chk($sformatf("%s.done@%0d",   e_mon.tag, cyc - base), bus.DONE,       e_mon.d);
        chk($sformatf("%s.missed@%0d", e_mon.tag, cyc - base), bus.MISSED_CNT, e_mon.m);
      end
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic at(input int rel);
    at_cyc(base + rel);
  endtask

  task automatic pulse(input int t);
    at(t);   bus.TRIG = 1'b1;
    at(t+1); bus.TRIG = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && q.size() > 0; i++) @(posedge CLK);
    chk({tag, ".drain"}, q.size(), 0);
  endtask

  task automatic do_reset(input bit check_rst);
    bus.TRIG = 1'b0;
    bus.EN   = 1'b0;
    #1 RSTN  = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    if (check_rst) begin
      chk("rst.out",    bus.OUT_PULSE,  0);
      chk("rst.busy",   bus.BUSY,       0);
      chk("rst.done",   bus.DONE,       0);
      chk("rst.missed", bus.MISSED_CNT, 0);
    end
    at_cyc(cyc + 1);
    RSTN = 1'b1;
    base = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN = 1'b0;
    bus.EN = 1'b0; bus.TRIG = 1'b0; bus.WIDTH = '0; bus.HOLDOFF = '0;

    // T1: W=3 H=2
    do_reset(1'b1);
    bus.EN = 1'b1; bus.WIDTH = 8'd3; bus.HOLDOFF = 8'd2;
    push_win("t1", 9, 18, rng(11,13), rng(11,15), rng(16,16), 32'd0);
    pulse(10);
    drain("t1");

    // T2: W=0 H=0, second trigger on the DONE cycle
    do_reset(1'b0);
    bus.EN = 1'b1; bus.WIDTH = 8'd0; bus.HOLDOFF = 8'd0;
    push_win("t2", 9, 16, rng(11,11) | rng(13,13), rng(11,11) | rng(13,13),
             rng(12,12) | rng(14,14), 32'd0);
    pulse(10);
    pulse(12);
    drain("t2");

    // T3: W=4 H=3, triggers at 10, 12, 16
    do_reset(1'b0);
    bus.EN = 1'b1; bus.WIDTH = 8'd4; bus.HOLDOFF = 8'd3;
`ifdef PULSE_STRETCH_RETRIGGER_EN
    push_win("t3", 9, 22, rng(11,16), rng(11,19), rng(20,20), rng(16,16));
`else
    push_win("t3", 9, 20, rng(11,14), rng(11,17), rng(18,18), rng(12,12) | rng(16,16));
`endif
    pulse(10);
    pulse(12);
    pulse(16);
    drain("t3");

    // T4: EN=0 ignores TRIG; EN drop mid-pulse lets the pulse finish
    do_reset(1'b0);
    bus.EN = 1'b0; bus.WIDTH = 8'd4; bus.HOLDOFF = 8'd1;
    push_win("t4a", 9, 14, 32'd0, 32'd0, 32'd0, 32'd0);
    pulse(10);
    push_win("t4b", 19, 28, rng(21,24), rng(21,25), rng(26,26), 32'd0);
    at(18); bus.EN = 1'b1;
    pulse(20);
    at(22); bus.EN = 1'b0;
    pulse(23);
    drain("t4");

    // T5: TRIG held 300 cycles, W=1 H=255 -> MISSED_CNT saturates
    do_reset(1'b0);
    bus.EN = 1'b1; bus.WIDTH = 8'd1; bus.HOLDOFF = 8'd255;
    push_one("t5", 11,  1'b1, 1'b1, 1'b0, 8'd0);
    push_one("t5", 266, 1'b0, 1'b1, 1'b0, 8'd255);
    push_one("t5", 267, 1'b0, 1'b0, 1'b1, 8'd255);
    push_one("t5", 268, 1'b1, 1'b1, 1'b0, 8'd255);
    push_one("t5", 310, 1'b0, 1'b1, 1'b0, 8'd255);
    at(10); bus.TRIG = 1'b1;
    at(310); bus.TRIG = 1'b0;
    drain("t5");

    // T6: reset mid-pulse, W=5 H=0
    do_reset(1'b0);
    bus.EN = 1'b1; bus.WIDTH = 8'd5; bus.HOLDOFF = 8'd0;
    push_win("t6", 9, 20, rng(11,11), rng(11,11), 32'd0, 32'd0);
    pulse(10);
    at(12);
    #1 RSTN = 1'b0;
    #1;
    chk("t6.async.out",  bus.OUT_PULSE, 0);
    chk("t6.async.busy", bus.BUSY,      0);
    chk("t6.async.done", bus.DONE,      0);
    at(14); RSTN = 1'b1;
    drain("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
